// File: rtl/clock_seg_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clock_seg_display                                                |
// | Scans six BCD time digits onto a common-anode 7-segment display, with      |
// | anti-ghost blank gaps and blinking of the field being edited in set mode.  |
// | Optional: DISP_COLON_EN lights dp on slots 2 and 4 as HH.MM.SS separators. |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module clock_seg_display #(
    parameter int SCAN_DIV    = 100_000,
    parameter int BLANK_CYC   = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk_100MHz,
    input  logic       rst_time,
    input  logic [3:0] L_sec,
    input  logic [3:0] H_sec,
    input  logic [3:0] L_min,
    input  logic [3:0] H_min,
    input  logic [3:0] L_hour,
    input  logic [3:0] H_hour,
    input  logic [1:0] select_time,
    input  logic       change,
    output logic [7:0] an,
    output logic [7:0] seg
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_TICKS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] slot_cnt;
    logic [2:0]       slot_idx;
    logic [3:0]       dig_q;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;
    logic             change_q;
    logic [1:0]       select_q;

    logic             slot_tick;
    logic             blink_restart;
    logic [3:0]       dig_sel;
    logic [6:0]       seg_dec;
    logic             field_hit;
    logic             masked;
    logic             dp_n;

    assign slot_tick     = (slot_cnt == SLOT_LAST);
    assign blink_restart = (change && !change_q) || (select_time != select_q);

    always_comb begin
        dig_sel = L_sec;
        case (slot_idx)
            3'd0:    dig_sel = L_sec;
            3'd1:    dig_sel = H_sec;
            3'd2:    dig_sel = L_min;
            3'd3:    dig_sel = H_min;
            3'd4:    dig_sel = L_hour;
            3'd5:    dig_sel = H_hour;
            default: dig_sel = L_sec;
        endcase
    end

    // Segment order g..a, active-low; non-BCD codes render as a lone dash.
    always_comb begin
        seg_dec = 7'b0111111;
        case (dig_q)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b0111111;
        endcase
    end

    // Slot pairs map onto fields: index/2 gives 0=sec, 1=min, 2=hour.
    assign field_hit = (select_time != 2'd3) && (slot_idx[2:1] == select_time);
    assign masked    = change && !blink_on && field_hit;

`ifdef DISP_COLON_EN
    assign dp_n = !((slot_idx == 3'd2) || (slot_idx == 3'd4));
`else
    assign dp_n = 1'b1;
`endif

    always_ff @(posedge clk_100MHz or negedge rst_time) begin
        if (!rst_time) begin
            slot_cnt <= '0;
            slot_idx <= 3'd0;
        end else begin
            slot_cnt <= slot_tick ? '0 : slot_cnt + 1'b1;
            if (slot_tick)
                slot_idx <= (slot_idx == 3'd5) ? 3'd0 : slot_idx + 3'd1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_time) begin
        if (!rst_time) begin
            state <= ST_BLANK;
            dig_q <= 4'd0;
            an    <= 8'hFF;
            seg   <= 8'hFF;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (slot_cnt == BLANK_LAST) begin
                        state <= ST_ON;
                        dig_q <= dig_sel;
                    end
                end
                ST_ON: begin
                    if (slot_tick)
                        state <= ST_BLANK;
                end
                default: state <= ST_BLANK;
            endcase

            if (state == ST_ON) begin
                an  <= ~(8'd1 << slot_idx);
                seg <= masked ? 8'hFF : {dp_n, seg_dec};
            end else begin
                an  <= 8'hFF;
                seg <= 8'hFF;
            end
        end
    end

    // An edit action restarts the blink with the field visible, overriding a toggle.
    always_ff @(posedge clk_100MHz or negedge rst_time) begin
        if (!rst_time) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            change_q  <= 1'b0;
            select_q  <= 2'd3;
        end else begin
            change_q <= change;
            select_q <= select_time;
            if (blink_restart) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (slot_tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= !blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_seg_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_clock_seg_display                                             |
// | Scoreboard bench for clock_seg_display (SCAN_DIV=10, BLANK_CYC=2,          |
// | BLINK_TICKS=4); honours DISP_COLON_EN.                                     |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_clock_seg_display;

    localparam int SD = 10;
    localparam int BC = 2;
    localparam int BT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] L_sec = 4'd0, H_sec = 4'd0, L_min = 4'd0, H_min = 4'd0;
    logic [3:0] L_hour = 4'd0, H_hour = 4'd0;
    logic [1:0] select_time = 2'd3;
    logic       change = 1'b0;
    logic [7:0] an;
    logic [7:0] seg;

    always #5 clk = ~clk;

    clock_seg_display #(
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC),
        .BLINK_TICKS(BT)
    ) dut (
        .clk_100MHz (clk),
        .rst_time   (rst_n),
        .L_sec      (L_sec),
        .H_sec      (H_sec),
        .L_min      (L_min),
        .H_min      (H_min),
        .L_hour     (L_hour),
        .H_hour     (H_hour),
        .select_time(select_time),
        .change     (change),
        .an         (an),
        .seg        (seg)
    );

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc;
    int   slot;
    int   restart_slot;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, want);
        end
    endtask

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Posedges since reset release; output after edge n reflects counter value (n-1)%SD.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                check_val($sformatf("an@%0d", mon_e.cyc), an, mon_e.an);
                check_val($sformatf("seg@%0d", mon_e.cyc), seg, mon_e.seg);
            end
        end
    end

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                check_val($sformatf("timeout_cyc%0d", target), 8'd1, 8'd0);
                break;
            end
        end
    endtask

    // Expected output for every cycle of slot s, using the inputs present at its latch edge.
    task automatic push_slot(input int s);
        int         idx;
        logic [3:0] d;
        logic       blink, mask, dp;
        exp_t       e;
        idx = s % 6;
        case (idx)
            0: d = L_sec;
            1: d = H_sec;
            2: d = L_min;
            3: d = H_min;
            4: d = L_hour;
            default: d = H_hour;
        endcase
        blink = (((s - restart_slot) / BT) % 2) == 0;
        mask  = change && !blink && (select_time != 2'd3) && ((idx / 2) == int'(select_time));
`ifdef DISP_COLON_EN
        dp = !(idx == 2 || idx == 4);
`else
        dp = 1'b1;
`endif
        for (int k = 0; k < SD; k++) begin
            e.cyc = SD * s + k + 1;
            if (k < BC) begin
                e.an  = 8'hFF;
                e.seg = 8'hFF;
            end else begin
                e.an  = ~(8'd1 << idx);
                e.seg = mask ? 8'hFF : {dp, dec7(d)};
            end
            sb.push_back(e);
        end
    endtask

    // Returns mid-ON of the slot so callers can disturb inputs there.
    task automatic run_slot();
        wait_cyc(SD * slot);
        push_slot(slot);
        wait_cyc(SD * slot + 5);
        slot++;
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        #1;
        check_val("rst_an", an, 8'hFF);
        check_val("rst_seg", seg, 8'hFF);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n        = 1'b1;
        slot         = 0;
        restart_slot = 0;
    endtask

    task automatic drain();
        wait_cyc(SD * slot + 1);
        check_val("sb_drain", 8'(sb.size()), 8'd0);
    endtask

    initial begin
        slot         = 0;
        restart_slot = 0;
        repeat (3) @(negedge clk);
        check_val("init_an", an, 8'hFF);
        check_val("init_seg", seg, 8'hFF);

        // Scan order on 12:34:56, including the wrap back to slot 0.
        {H_hour, L_hour, H_min, L_min, H_sec, L_sec} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        change = 1'b0;
        select_time = 2'd3;
        reset_release();
        repeat (8) run_slot();
        reset_assert();

        // Invalid BCD shows a dash; a mid-slot digit change waits for the next visit.
        L_sec = 4'hC;
        reset_release();
        run_slot();
        L_sec = 4'd7;
        repeat (7) run_slot();
        reset_assert();

        // Blink the minutes field.
        L_sec = 4'd6;
        change = 1'b1;
        select_time = 2'd1;
        reset_release();
        repeat (16) run_slot();
        reset_assert();

        // Switching field during blink-off restarts the blink visible.
        reset_release();
        repeat (7) run_slot();
        select_time  = 2'd2;
        restart_slot = slot - 1;
        repeat (12) run_slot();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
